aurora_tx_arbiter: RTL and testbench

Round-robin packet arbiter that shares the single Aurora TX user AXI-Stream port between N_REQ requesters, such as the matrix-multiplier result engines.
Each granted packet goes out as one header beat carrying the source ID, followed by the requester's data beats passed through unchanged.
Transmission is gated by the Aurora channel_up. A link loss mid-packet aborts that packet: the rest of it is flushed from the requester and the loss is counted.
Sits between the compute datapath and the Aurora core TX interface.

---
 rtl/aurora_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_aurora_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_tx_arbiter.sv
// Round-robin packet arbiter onto the Aurora TX AXI-Stream port.
// Each packet is sent as a tagged header beat followed by the requester data.
module aurora_tx_arbiter #(
  parameter int          N_REQ   = 4,
  parameter int          DATA_W  = 32,
  parameter logic [7:0]  HDR_TAG = 8'hA5
) (
  input  logic                      clk_200MHz,
  input  logic                      peripheral_reset,
  input  logic                      channel_up,
  input  logic [N_REQ*DATA_W-1:0]   s_tdata,
  input  logic [N_REQ-1:0]          s_tvalid,
  input  logic [N_REQ-1:0]          s_tlast,
  output logic [N_REQ-1:0]          s_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic [3:0]                drop_count
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    FLUSH
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   last_q;
  logic [3:0]      drop_q;

  logic [DATA_W-1:0] s_data [N_REQ];
  logic [DATA_W-1:0] g_data;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] hdr;
  logic              pick_vld;
  logic [GW-1:0]     pick_id;
  logic [GW-1:0]     cand;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      s_data[i] = s_tdata[i*DATA_W +: DATA_W];
    end
  end

  assign g_data  = s_data[grant_q];
  assign g_valid = s_tvalid[grant_q];
  assign g_last  = s_tlast[grant_q];

  always_comb begin
    hdr                 = '0;
    hdr[DATA_W-1 -: 8]  = HDR_TAG;
    hdr[GW-1:0]         = grant_q;
  end

  // Search starts just after the last served requester and wraps.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GW'((int'(last_q) + k) % N_REQ);
      if (!pick_vld && s_tvalid[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_ff @(posedge clk_200MHz) begin
    if (peripheral_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_REQ - 1);
      drop_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (channel_up && pick_vld) begin
            grant_q <= pick_id;
            state_q <= HDR;
          end
        end
        HDR: begin
          if (!channel_up) begin
            state_q <= FLUSH;
            if (drop_q != 4'hF) drop_q <= drop_q + 4'd1;
          end else if (m_tready) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (!channel_up) begin
            state_q <= FLUSH;
            if (drop_q != 4'hF) drop_q <= drop_q + 4'd1;
          end else if (g_valid && m_tready && g_last) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end
        end
        FLUSH: begin
          if (g_valid && g_last) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (!peripheral_reset) begin
      unique case (state_q)
        IDLE: begin
        end
        HDR: begin
          m_tdata  = hdr;
          m_tvalid = channel_up;
        end
        DATA: begin
          m_tdata           = g_data;
          m_tvalid          = g_valid && channel_up;
          m_tlast           = g_last;
          s_tready[grant_q] = m_tready && channel_up;
        end
        FLUSH: begin
          s_tready[grant_q] = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign grant_id   = peripheral_reset ? '0 : grant_q;
  assign busy       = !peripheral_reset && (state_q != IDLE);
  assign drop_count = peripheral_reset ? 4'd0 : drop_q;

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Directed bench for aurora_tx_arbiter: requester queues drive the
// slave ports, a monitor captures the master stream.
`timescale 1ns/1ps
module tb_aurora_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              channel_up = 1'b0;
  logic [NR*DW-1:0]  s_tdata = '0;
  logic [NR-1:0]     s_tvalid = '0;
  logic [NR-1:0]     s_tlast = '0;
  logic [NR-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready = 1'b0;
  logic [1:0]        grant_id;
  logic              busy;
  logic [3:0]        drop_count;

  int tests = 0;
  int fails = 0;

  logic [DW:0] srcq [NR][$];
  logic [DW:0] mq [$];
  int          s_hs [NR];

  aurora_tx_arbiter #(
    .N_REQ(NR), .DATA_W(DW), .HDR_TAG(8'hA5)
  ) dut (
    .clk_200MHz(clk),
    .peripheral_reset(rst),
    .channel_up(channel_up),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tlast(m_tlast),
    .m_tready(m_tready),
    .grant_id(grant_id),
    .busy(busy),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NR; r++) s_hs[r] = 0;
  end

  // Requester models: pop on handshake, present queue head.
  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) begin
      if (s_tvalid[r] && s_tready[r] && srcq[r].size() > 0) begin
        void'(srcq[r].pop_front());
        s_hs[r] = s_hs[r] + 1;
      end
    end
    #1;
    for (int r = 0; r < NR; r++) begin
      if (srcq[r].size() > 0) begin
        s_tvalid[r]            = 1'b1;
        s_tlast[r]             = srcq[r][0][DW];
        s_tdata[r*DW +: DW]    = srcq[r][0][DW-1:0];
      end else begin
        s_tvalid[r]            = 1'b0;
        s_tlast[r]             = 1'b0;
        s_tdata[r*DW +: DW]    = '0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && m_tvalid && m_tready) mq.push_back({m_tlast, m_tdata});
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int r = 0; r < NR; r++) n += srcq[r].size();
    return n;
  endfunction

  task automatic wait_beats(int n, string tag);
    int c = 0;
    while (mq.size() < n && c < 300) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_beats"}, 64'(mq.size() >= n), 1);
  endtask

  task automatic wait_idle(string tag);
    int c = 0;
    while ((busy || pending() != 0) && c < 300) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_idle"}, 64'(busy || pending() != 0), 0);
  endtask

  task automatic do_reset(bit clr);
    @(negedge clk);
    rst = 1'b1;
    channel_up = 1'b0;
    m_tready = 1'b0;
    if (clr) begin
      for (int r = 0; r < NR; r++) srcq[r].delete();
    end
    mq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drop_pkt();
    int base = mq.size();
    channel_up = 1'b1;
    m_tready = 1'b1;
    for (int k = 0; k < 5; k++) srcq[0].push_back({k == 4, 32'hF0 + k});
    wait_beats(base + 3, "drop");
    channel_up = 1'b0;
    wait_idle("drop");
  endtask

  initial begin
    logic [3:0]    pat;
    logic          held;
    logic [DW-1:0] held_d;
    int            hold_err;
    int            mirror_err;
    int            stall_cnt;
    int            hs0;
    int            cyc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mvalid", m_tvalid, 0);
    check("rst_grant", grant_id, 0);
    check("rst_drop", drop_count, 0);
    check("rst_sready", s_tready, 0);
    rst = 1'b0;
    #1;
    check("rel_busy", busy, 0);
    check("rel_mvalid", m_tvalid, 0);

    // 1: three-beat packet from requester 1
    channel_up = 1'b1;
    m_tready = 1'b1;
    srcq[1].push_back({1'b0, 32'h11});
    srcq[1].push_back({1'b0, 32'h22});
    srcq[1].push_back({1'b1, 32'h33});
    wait_beats(4, "t1");
    check("t1_busy_fall", busy, 0);
    check("t1_hdr", mq[0], {1'b0, 32'hA500_0001});
    check("t1_d0", mq[1], {1'b0, 32'h11});
    check("t1_d1", mq[2], {1'b0, 32'h22});
    check("t1_d2", mq[3], {1'b1, 32'h33});
    check("t1_grant", grant_id, 1);

    // 2: all requesters contend with one-beat packets
    do_reset(1);
    channel_up = 1'b1;
    m_tready = 1'b1;
    for (int r = 0; r < NR; r++) begin
      srcq[r].push_back({1'b1, 32'h200 + r * 16});
      srcq[r].push_back({1'b1, 32'h201 + r * 16});
    end
    wait_beats(10, "t2");
    check("t2_h0", mq[0], {1'b0, 32'hA500_0000});
    check("t2_h1", mq[2], {1'b0, 32'hA500_0001});
    check("t2_h2", mq[4], {1'b0, 32'hA500_0002});
    check("t2_h3", mq[6], {1'b0, 32'hA500_0003});
    check("t2_h4", mq[8], {1'b0, 32'hA500_0000});
    check("t2_d0", mq[1], {1'b1, 32'h200});
    check("t2_d3", mq[7], {1'b1, 32'h230});
    check("t2_d4", mq[9], {1'b1, 32'h201});

    // 3: back-pressure pattern 1,0,0,1 on requester 2
    do_reset(1);
    channel_up = 1'b1;
    pat = 4'b1001;
    held = 1'b0;
    held_d = '0;
    hold_err = 0;
    mirror_err = 0;
    stall_cnt = 0;
    cyc = 0;
    hs0 = s_hs[2];
    for (int k = 0; k < 4; k++) srcq[2].push_back({k == 3, 32'hC1 + k});
    while (!(mq.size() >= 5 && !busy) && cyc < 100) begin
      @(negedge clk);
      if (held && m_tdata !== held_d) hold_err++;
      held = 1'b0;
      m_tready = pat[cyc % 4];
      #1;
      if (busy && mq.size() >= 1 && s_tready[2] !== m_tready) mirror_err++;
      if (m_tvalid && !m_tready) begin
        held = 1'b1;
        held_d = m_tdata;
        stall_cnt++;
      end
      cyc++;
    end
    check("t3_done", 64'(cyc < 100), 1);
    repeat (3) @(negedge clk);
    check("t3_nbeats", mq.size(), 5);
    check("t3_hdr", mq[0], {1'b0, 32'hA500_0002});
    check("t3_d0", mq[1], {1'b0, 32'hC1});
    check("t3_d3", mq[4], {1'b1, 32'hC4});
    check("t3_hold", hold_err, 0);
    check("t3_stalled", 64'(stall_cnt > 0), 1);
    check("t3_mirror", mirror_err, 0);
    check("t3_s_hs", s_hs[2] - hs0, 4);
    m_tready = 1'b1;

    // 4: link drops after two data beats of a five-beat packet
    do_reset(1);
    channel_up = 1'b1;
    m_tready = 1'b1;
    for (int k = 0; k < 5; k++) srcq[0].push_back({k == 4, 32'hD1 + k});
    wait_beats(3, "t4");
    channel_up = 1'b0;
    #1;
    check("t4_mvalid_low", m_tvalid, 0);
    check("t4_sready_low", s_tready[0], 0);
    wait_idle("t4");
    check("t4_drop", drop_count, 1);
    check("t4_nbeats", mq.size(), 3);
    srcq[1].push_back({1'b1, 32'h77});
    repeat (5) @(negedge clk);
    check("t4_hold_busy", busy, 0);
    check("t4_hold_beats", mq.size(), 3);
    channel_up = 1'b1;
    wait_beats(5, "t4b");
    check("t4_new_hdr", mq[3], {1'b0, 32'hA500_0001});
    check("t4_new_d", mq[4], {1'b1, 32'h77});

    // 5: drop counter saturates
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      drop_pkt();
      if (i == 13) check("t5_drop14", drop_count, 14);
      if (i == 14) check("t5_drop15", drop_count, 15);
    end
    check("t5_sat", drop_count, 15);

    // 6: reset during requester 3 data phase
    do_reset(1);
    channel_up = 1'b1;
    m_tready = 1'b1;
    srcq[3].push_back({1'b0, 32'hE1});
    srcq[3].push_back({1'b0, 32'hE2});
    srcq[3].push_back({1'b1, 32'hE3});
    wait_beats(2, "t6");
    srcq[0].push_back({1'b1, 32'h0F});
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_mvalid", m_tvalid, 0);
    check("t6_rst_mdata", m_tdata, 0);
    check("t6_rst_sready", s_tready, 0);
    check("t6_rst_grant", grant_id, 0);
    @(negedge clk);
    check("t6_next_busy", busy, 0);
    check("t6_next_mvalid", m_tvalid, 0);
    mq.delete();
    rst = 1'b0;
    #1;
    check("t6_rel_busy", busy, 0);
    check("t6_rel_grant", grant_id, 0);
    wait_beats(3, "t6b");
    check("t6_first_hdr", mq[0], {1'b0, 32'hA500_0000});
    check("t6_first_d", mq[1], {1'b1, 32'h0F});
    check("t6_second_hdr", mq[2], {1'b0, 32'hA500_0003});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
